// File: rtl/counter_cmd_ctrl_if.sv
// Bus between a command source, counter_cmd_ctrl and the universal_bin_counter it steers:
// valid/ready command channel, counter control/status lines and controller status.
interface counter_cmd_ctrl_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_arg;

  logic         cnt_en;
  logic         cnt_up;
  logic         cnt_load;
  logic         cnt_syn_clr;
  logic [N-1:0] cnt_d;
  logic         cnt_max_tick;
  logic         cnt_min_tick;

  logic         busy;
  logic         done;
  logic         sat;

  // master: the host plus the counter feeding back its boundary ticks
  modport master (
    output cmd_valid, cmd_op, cmd_arg, cnt_max_tick, cnt_min_tick,
    input  cmd_ready, cnt_en, cnt_up, cnt_load, cnt_syn_clr, cnt_d, busy, done, sat
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cnt_max_tick, cnt_min_tick,
    output cmd_ready, cnt_en, cnt_up, cnt_load, cnt_syn_clr, cnt_d, busy, done, sat
  );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// Command sequencer for one universal_bin_counter: CLEAR/LOAD/COUNT_UP/COUNT_DOWN over valid/ready,
// COUNT steps paced by a DIV-cycle prescaler tick. Define CNTCTRL_SAT_EN to end a COUNT early at a boundary.
module counter_cmd_ctrl #(
  parameter int N   = 4,
  parameter int DIV = 25_000_000
) (
  input logic               clk,
  input logic               reset,
  counter_cmd_ctrl_if.slave bus
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  ONE_STEP   = N'(1);
  localparam logic [1:0]    OP_CLEAR   = 2'b00;
  localparam logic [1:0]    OP_LOAD    = 2'b01;
  localparam logic [1:0]    OP_UP      = 2'b10;

  typedef enum logic [1:0] {IDLE, APPLY, RUN, DONE} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [N-1:0]  step_q;
  logic [N-1:0]  cnt_d_q;
  logic          cnt_up_q;
  logic          cnt_load_q;
  logic          cnt_syn_clr_q;
  logic          done_q;
  logic          sat_q;

  logic          tick;
  logic          satHit;

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // Boundary gating is the one combinational path into cnt_en.
`ifdef CNTCTRL_SAT_EN
  assign satHit = tick && ((cnt_up_q && bus.cnt_max_tick) || (!cnt_up_q && bus.cnt_min_tick));
`else
  assign satHit = 1'b0;
`endif

  assign bus.cnt_en      = tick && !satHit;
  assign bus.cnt_up      = cnt_up_q;
  assign bus.cnt_load    = cnt_load_q;
  assign bus.cnt_syn_clr = cnt_syn_clr_q;
  assign bus.cnt_d       = cnt_d_q;
  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.sat         = sat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      step_q        <= '0;
      cnt_d_q       <= '0;
      cnt_up_q      <= 1'b0;
      cnt_load_q    <= 1'b0;
      cnt_syn_clr_q <= 1'b0;
      done_q        <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      cnt_load_q    <= 1'b0;
      cnt_syn_clr_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            sat_q <= 1'b0;
            case (bus.cmd_op)
              OP_CLEAR: begin
                state_q       <= APPLY;
                cnt_syn_clr_q <= 1'b1;
              end
              OP_LOAD: begin
                state_q    <= APPLY;
                cnt_load_q <= 1'b1;
                cnt_d_q    <= bus.cmd_arg;
              end
              default: begin
                step_q <= bus.cmd_arg;
                if (bus.cmd_arg == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q  <= RUN;
                  presc_q  <= '0;
                  cnt_up_q <= (bus.cmd_op == OP_UP);
                end
              end
            endcase
          end
        end
        APPLY: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        RUN: begin
          if (tick) begin
            presc_q <= '0;
            if (satHit) begin
              sat_q   <= 1'b1;
              step_q  <= '0;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              step_q <= step_q - ONE_STEP;
              if (step_q == ONE_STEP) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl (N=4, DIV=4) with a reference counter on the cnt_* lines and a
// timeline model of the controller; follows CNTCTRL_SAT_EN the same way the design does.
`timescale 1ns/1ps
module tb_counter_cmd_ctrl;

  localparam int         N        = 4;
  localparam int         DIV      = 4;
  localparam int         QMAX     = (1 << N) - 1;
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_cmd_ctrl_if #(.N(N)) bus ();

  counter_cmd_ctrl #(.N(N), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  int edgeCount    = 0;
  int enTotal      = 0;
  int loadTotal    = 0;
  int clrTotal     = 0;
  int doneCount    = 0;
  int lastDoneEdge = -1;
  int lastAccept   = 0;
  int enBase, loadBase, clrBase, doneBase;

  logic [N-1:0] refQ;

  // Controller model: a command is a timeline of cycles r = 0.. after its accepting edge.
  bit           mActive  = 1'b0;
  bit           mIsCount = 1'b0;
  bit           mUp      = 1'b0;
  bit           mSat     = 1'b0;
  bit           mSatPlan = 1'b0;
  logic [1:0]   mOp      = 2'b00;
  logic [N-1:0] mD       = '0;
  int           mR       = 0;
  int           mDoneR   = 0;
  int           mLastJ   = 0;
  int           mK       = 0;
  int           mRoom    = 0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                refQ <= '0;
    else if (bus.cnt_syn_clr) refQ <= '0;
    else if (bus.cnt_load)    refQ <= bus.cnt_d;
    else if (bus.cnt_en)      refQ <= bus.cnt_up ? refQ + 1'b1 : refQ - 1'b1;
  end

  assign bus.cnt_max_tick = (refQ == N'(QMAX));
  assign bus.cnt_min_tick = (refQ == '0);

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always @(negedge clk) begin
    if (bus.cnt_en === 1'b1)      enTotal++;
    if (bus.cnt_load === 1'b1)    loadTotal++;
    if (bus.cnt_syn_clr === 1'b1) clrTotal++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at edge %0d", name, actual, expected, edgeCount);
  endtask

  task automatic compareModel();
    int  r1;
    bit  expEn;
    r1    = mR + 1;
    expEn = mActive && mIsCount && (r1 % DIV == 0) && (r1 / DIV <= mLastJ);
    checkOutput("cmd_ready", bus.cmd_ready, !mActive);
    checkOutput("busy", bus.busy, mActive);
    checkOutput("done", bus.done, mActive && (mR == mDoneR));
    checkOutput("cnt_en", bus.cnt_en, expEn);
    checkOutput("cnt_load", bus.cnt_load, mActive && !mIsCount && (mOp == OP_LOAD) && (mR == 0));
    checkOutput("cnt_syn_clr", bus.cnt_syn_clr, mActive && !mIsCount && (mOp == OP_CLEAR) && (mR == 0));
    checkOutput("cnt_up", bus.cnt_up, mUp);
    checkOutput("cnt_d", bus.cnt_d, mD);
    checkOutput("sat", bus.sat, mSat || (mActive && mSatPlan && (mR == mDoneR)));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mActive  = 1'b0;
      mUp      = 1'b0;
      mD       = '0;
      mSat     = 1'b0;
      mSatPlan = 1'b0;
      mR       = 0;
    end else begin
      if (mActive) begin
        mR++;
        if (mR > mDoneR) begin
          mActive = 1'b0;
          mSat    = mSatPlan;
        end
      end else if (bus.cmd_valid === 1'b1) begin
        mActive  = 1'b1;
        mR       = 0;
        mOp      = bus.cmd_op;
        mSat     = 1'b0;
        mSatPlan = 1'b0;
        mIsCount = bus.cmd_op[1];
        if (!mIsCount) begin
          mDoneR = 1;
          mLastJ = 0;
          if (bus.cmd_op == OP_LOAD) mD = bus.cmd_arg;
        end else begin
          mK     = int'(bus.cmd_arg);
          mLastJ = mK;
          mDoneR = mK * DIV;
          if (mK > 0) begin
            mUp = (bus.cmd_op == OP_UP);
`ifdef CNTCTRL_SAT_EN
            mRoom = mUp ? (QMAX - int'(refQ)) : int'(refQ);
            if (mK > mRoom) begin
              mLastJ   = mRoom;
              mDoneR   = (mRoom + 1) * DIV;
              mSatPlan = 1'b1;
            end
`endif
          end
        end
      end
      #1;
      if (bus.done === 1'b1) begin
        doneCount++;
        lastDoneEdge = edgeCount;
      end
      compareModel();
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [N-1:0] arg, output int acceptEdge);
    int waitCycles = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 100) checkOutput("readyTimeout", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(posedge clk);
    #1;
    acceptEdge = edgeCount;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~op;
    bus.cmd_arg   = ~arg;
  endtask

  task automatic waitDone(input int base);
    int waitCycles = 0;
    while (doneCount <= base && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (doneCount <= base) checkOutput("doneTimeout", doneCount, base + 1);
  endtask

  task automatic captureBases();
    enBase   = enTotal;
    loadBase = loadTotal;
    clrBase  = clrTotal;
    doneBase = doneCount;
  endtask

  task automatic runCommand(input logic [1:0] op, input logic [N-1:0] arg);
    int db;
    db = doneCount;
    applyStimulus(op, arg, lastAccept);
    waitDone(db);
    @(negedge clk);
  endtask

  int accA, accB, guard;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_CLEAR;
    bus.cmd_arg   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstEn", bus.cnt_en, 0);
    checkOutput("rstLoad", bus.cnt_load, 0);
    checkOutput("rstClr", bus.cnt_syn_clr, 0);
    checkOutput("rstUp", bus.cnt_up, 0);
    checkOutput("rstD", bus.cnt_d, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstSat", bus.sat, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstReady", bus.cmd_ready, 1);

    captureBases();
    runCommand(OP_LOAD, 4'hA);
    checkOutput("loadQ", refQ, 4'hA);
    checkOutput("loadPulses", loadTotal - loadBase, 1);
    checkOutput("loadDoneEdge", lastDoneEdge - lastAccept, 1);
    checkOutput("loadReadyBack", bus.cmd_ready, 1);

    runCommand(OP_LOAD, 4'h7);
    checkOutput("load7Q", refQ, 4'h7);
    captureBases();
    runCommand(OP_CLEAR, 4'h5);
    checkOutput("clearQ", refQ, 4'h0);
    checkOutput("clearPulses", clrTotal - clrBase, 1);
    checkOutput("clearDoneEdge", lastDoneEdge - lastAccept, 1);

    runCommand(OP_LOAD, 4'h2);
    captureBases();
    runCommand(OP_UP, 4'd3);
    checkOutput("up3Pulses", enTotal - enBase, 3);
    checkOutput("up3Q", refQ, 4'h5);
    checkOutput("up3DoneEdge", lastDoneEdge - lastAccept, 12);
    checkOutput("up3Sat", bus.sat, 0);

    runCommand(OP_LOAD, 4'hD);
    captureBases();
    runCommand(OP_UP, 4'd5);
`ifdef CNTCTRL_SAT_EN
    checkOutput("up5Pulses", enTotal - enBase, 2);
    checkOutput("up5Q", refQ, 4'hF);
    checkOutput("up5Sat", bus.sat, 1);
    checkOutput("up5DoneEdge", lastDoneEdge - lastAccept, 12);
`else
    checkOutput("up5Pulses", enTotal - enBase, 5);
    checkOutput("up5Q", refQ, 4'h2);
    checkOutput("up5Sat", bus.sat, 0);
    checkOutput("up5DoneEdge", lastDoneEdge - lastAccept, 20);
`endif

    // Hold cmd_valid through a COUNT with a different command on the bus.
    runCommand(OP_LOAD, 4'h3);
    captureBases();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_UP;
    bus.cmd_arg   = 4'd2;
    @(posedge clk);
    #1;
    accA = edgeCount;
    @(negedge clk);
    bus.cmd_op  = OP_DOWN;
    bus.cmd_arg = 4'd0;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("heldReadyTimeout", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    accB = edgeCount;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("down0DoneEdge", lastDoneEdge, accB);
    repeat (3) @(negedge clk);
    checkOutput("heldPulses", enTotal - enBase, 2);
    checkOutput("heldQ", refQ, 4'h5);
    checkOutput("heldAcceptGap", accB - accA, 2 * DIV + 2);
    checkOutput("heldDoneCount", doneCount - doneBase, 2);
    checkOutput("heldReadyBack", bus.cmd_ready, 1);

    // Asynchronous reset in the middle of a COUNT_DOWN.
    runCommand(OP_LOAD, 4'h9);
    captureBases();
    applyStimulus(OP_DOWN, 4'd6, accA);
    guard = 0;
    while ((enTotal - enBase) < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("midPulseTimeout", enTotal - enBase, 2);
    @(negedge clk);
    checkOutput("preResetQ", refQ, 4'h7);
    checkOutput("preResetBusy", bus.busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstEn", bus.cnt_en, 0);
    checkOutput("midRstD", bus.cnt_d, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstDone", bus.done, 0);
    checkOutput("midRstSat", bus.sat, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("postRstPulses", enTotal - enBase, 2);
    checkOutput("postRstReady", bus.cmd_ready, 1);
    checkOutput("postRstQ", refQ, 4'h0);

    runCommand(OP_LOAD, 4'h1);
    checkOutput("recoverQ", refQ, 4'h1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
